plle2_drp_responder: RTL and testbench

//  Verilator-friendly model of the PLLE2 dynamic reconfiguration port (DRP), the responder side.
//  A DRP initiator (reconfig FSM or C++ bench) drives DEN/DWE/DADDR/DI. This block owns the
//  128x16 DRP register file, returns DRDY/DO with fixed latency and models LOCKED loss/reacquire
//  on reconfiguration. It exports decoded divide/multiply values so the bench can retune clocks.

---
 rtl/plle2_drp_responder.sv | 132 +++++++++++++
 tb/tb_plle2_drp_responder.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/plle2_drp_responder.sv
// PLLE2 DRP responder model: 128x16 register file, fixed-latency DRDY/DO and a
// LOCKED model that drops on every write commit or power-down.
module plle2_drp_responder #(
   parameter int DRP_LATENCY    = 3,
   parameter int LOCK_CYCLES    = 64,
   parameter int CLKFBOUT_MULT  = 5,
   parameter int DIVCLK_DIVIDE  = 1,
   parameter int CLKOUT0_DIVIDE = 1
) (
   input  logic        dclk,
   input  logic        rst,
   input  logic        pwrdwn,
   input  logic        den,
   input  logic        dwe,
   input  logic [6:0]  daddr,
   input  logic [15:0] di,
   output logic [15:0] dout,
   output logic        drdy,
   output logic        locked,
   output logic [6:0]  clkout0_div,
   output logic [6:0]  clkfbout_mul,
   output logic [6:0]  divclk_div,
   output logic        drp_err
);
   localparam logic [6:0]  ADDR_CLKOUT0 = 7'h08;
   localparam logic [6:0]  ADDR_FBOUT   = 7'h14;
   localparam logic [6:0]  ADDR_DIVCLK  = 7'h16;
   localparam logic [3:0]  CNT_LOAD     = 4'(DRP_LATENCY - 1);
   localparam logic [15:0] LOCK_LAST    = 16'(LOCK_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   typedef struct packed {
      logic        we;
      logic [6:0]  addr;
      logic [15:0] data;
   } req_t;

   // HIGH in [11:6] takes the odd half so HIGH+LOW reproduces V exactly.
   function automatic logic [15:0] enc(input int v);
      logic [5:0] hi;
      logic [5:0] lo;
      hi = 6'(v - v / 2);
      lo = 6'(v / 2);
      return {4'h0, hi, lo};
   endfunction

   state_t      state;
   logic [3:0]  cnt;
   req_t        req;
   req_t        cm;
   logic        commit;
   logic [15:0] regs [128];
   logic [15:0] lock_cnt;

   // Commit happens on the edge that raises DRDY; with unit latency that is the capture edge itself.
   always_comb begin
      commit = 1'b0;
      cm     = req;
      if (state == IDLE && den && DRP_LATENCY == 1) begin
         commit = 1'b1;
         cm     = '{we: dwe, addr: daddr, data: di};
      end else if (state == BUSY && cnt == 4'd1) begin
         commit = 1'b1;
      end
   end

   always_ff @(posedge dclk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= '0;
         req     <= '0;
         drdy    <= 1'b0;
         drp_err <= 1'b0;
      end else begin
         drdy <= commit;
         if (den && state != IDLE)
            drp_err <= 1'b1;
         case (state)
            IDLE: if (den) begin
               req   <= '{we: dwe, addr: daddr, data: di};
               cnt   <= CNT_LOAD;
               state <= (DRP_LATENCY == 1) ? DONE : BUSY;
            end
            BUSY: begin
               cnt <= cnt - 4'd1;
               if (cnt == 4'd1)
                  state <= DONE;
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge dclk or posedge rst) begin
      if (rst) begin
         dout <= '0;
         for (int i = 0; i < 128; i++)
            regs[i] <= 16'h0000;
         regs[ADDR_CLKOUT0] <= enc(CLKOUT0_DIVIDE);
         regs[ADDR_FBOUT]   <= enc(CLKFBOUT_MULT);
         regs[ADDR_DIVCLK]  <= enc(DIVCLK_DIVIDE);
      end else if (commit) begin
         if (cm.we)
            regs[cm.addr] <= cm.data;
         else
            dout <= regs[cm.addr];
      end
   end

   // A write commit restarts the count even on the edge the count would have completed.
   always_ff @(posedge dclk or posedge rst) begin
      if (rst) begin
         lock_cnt <= '0;
         locked   <= 1'b0;
      end else if (pwrdwn || (commit && cm.we)) begin
         lock_cnt <= '0;
         locked   <= 1'b0;
      end else if (!locked) begin
         if (lock_cnt == LOCK_LAST)
            locked <= 1'b1;
         else
            lock_cnt <= lock_cnt + 16'd1;
      end
   end

   assign clkout0_div  = {1'b0, regs[ADDR_CLKOUT0][11:6]} + {1'b0, regs[ADDR_CLKOUT0][5:0]};
   assign clkfbout_mul = {1'b0, regs[ADDR_FBOUT][11:6]}   + {1'b0, regs[ADDR_FBOUT][5:0]};
   assign divclk_div   = {1'b0, regs[ADDR_DIVCLK][11:6]}  + {1'b0, regs[ADDR_DIVCLK][5:0]};

endmodule

// File: tb/tb_plle2_drp_responder.sv
// Bench for plle2_drp_responder: directed scenarios plus random DRP/PWRDWN traffic
// checked every cycle against a transaction-level reference model.
module tb_plle2_drp_responder;
   localparam int LAT   = 3;
   localparam int LOCKN = 64;

   logic        dclk = 1'b0, rst = 1'b0, pwrdwn = 1'b0, den = 1'b0, dwe = 1'b0;
   logic [6:0]  daddr = '0;
   logic [15:0] di = '0;
   logic [15:0] dout;
   logic        drdy, locked, drp_err;
   logic [6:0]  clkout0_div, clkfbout_mul, divclk_div;

   int vectors = 0, miscompares = 0;

   always #5 dclk = ~dclk;

   plle2_drp_responder #(
      .DRP_LATENCY(LAT), .LOCK_CYCLES(LOCKN), .CLKFBOUT_MULT(5),
      .DIVCLK_DIVIDE(1), .CLKOUT0_DIVIDE(1)
   ) dut (
      .dclk(dclk), .rst(rst), .pwrdwn(pwrdwn), .den(den), .dwe(dwe),
      .daddr(daddr), .di(di), .dout(dout), .drdy(drdy), .locked(locked),
      .clkout0_div(clkout0_div), .clkfbout_mul(clkfbout_mul),
      .divclk_div(divclk_div), .drp_err(drp_err)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [15:0] enc(input int v);
      return 16'(((v - v / 2) << 6) | (v / 2));
   endfunction

   function automatic logic [6:0] dec(input logic [15:0] r);
      return 7'(r[11:6]) + 7'(r[5:0]);
   endfunction

   // Reference model: one transaction in flight, timed by absolute edge numbers.
   logic [15:0] mem [128];
   int          ec = 0, since = 0, busy_end = 0, commit_at = 0;
   logic        p_pend = 1'b0, p_we = 1'b0, wr = 1'b0;
   logic [6:0]  p_addr = '0;
   logic [15:0] p_data = '0;
   logic        exp_drdy = 1'b0, exp_err = 1'b0;
   logic [15:0] exp_dout = '0;

   always @(posedge dclk) begin
      ec++;
      wr = 1'b0;
      if (rst) begin
         for (int i = 0; i < 128; i++) mem[i] = 16'h0000;
         mem[8]  = enc(1);
         mem[20] = enc(5);
         mem[22] = enc(1);
         p_pend = 1'b0; busy_end = 0; since = 0;
         exp_drdy = 1'b0; exp_dout = '0; exp_err = 1'b0;
      end else begin
         exp_drdy = 1'b0;
         if (den) begin
            if (ec <= busy_end) exp_err = 1'b1;
            else begin
               p_pend = 1'b1; p_we = dwe; p_addr = daddr; p_data = di;
               commit_at = ec + LAT - 1;
               busy_end  = ec + LAT;
            end
         end
         if (p_pend && ec == commit_at) begin
            p_pend   = 1'b0;
            exp_drdy = 1'b1;
            if (p_we) begin
               mem[p_addr] = p_data;
               wr = 1'b1;
            end else exp_dout = mem[p_addr];
         end
         if (pwrdwn || wr) since = 0;
         else since++;
      end
      #1;
      chk("m_drdy", drdy, exp_drdy);
      chk("m_dout", dout, exp_dout);
      chk("m_err", drp_err, exp_err);
      chk("m_locked", locked, since >= LOCKN);
      chk("m_clkout0", clkout0_div, dec(mem[8]));
      chk("m_fbout", clkfbout_mul, dec(mem[20]));
      chk("m_divclk", divclk_div, dec(mem[22]));
   end

   task automatic drp(input logic we, input logic [6:0] a, input logic [15:0] d,
                      output int lat, output logic [15:0] rd);
      @(negedge dclk);
      den = 1'b1; dwe = we; daddr = a; di = d;
      lat = 0;
      do begin
         @(posedge dclk); #1;
         den = 1'b0;
         lat++;
      end while (!drdy && lat < 20);
      rd = dout;
   endtask

   task automatic edges_to_lock(output int n);
      n = 0;
      while (!locked && n < 200) begin
         @(posedge dclk); #1;
         n++;
      end
   endtask

   initial begin
      int          n, lat;
      logic [15:0] rd;

      #1 rst = 1'b1;
      repeat (2) @(posedge dclk);
      #1;
      chk("rst_clkout0", clkout0_div, 1);
      chk("rst_fbout", clkfbout_mul, 5);
      chk("rst_divclk", divclk_div, 1);
      chk("rst_drdy", drdy, 0);
      chk("rst_dout", dout, 0);
      chk("rst_locked", locked, 0);
      @(negedge dclk) rst = 1'b0;
      edges_to_lock(n);
      chk("lock_after_rst", n, LOCKN);

      drp(1'b0, 7'h14, 16'h0000, lat, rd);
      chk("rd_lat", lat, LAT);
      chk("rd_0x14", rd, 16'h00C2);
      @(posedge dclk); #1;
      chk("drdy_one_cycle", drdy, 0);

      drp(1'b1, 7'h08, 16'h0145, lat, rd);
      chk("wr_lat", lat, LAT);
      chk("wr_unlock", locked, 0);
      chk("wr_clkout0", clkout0_div, 10);
      chk("wr_dout_held", dout, 16'h00C2);
      edges_to_lock(n);
      chk("relock", n, LOCKN);
      drp(1'b0, 7'h08, 16'h0000, lat, rd);
      chk("readback", rd, 16'h0145);

      @(negedge dclk) pwrdwn = 1'b1;
      drp(1'b1, 7'h30, 16'hBEEF, lat, rd);
      chk("pd_wr_lat", lat, LAT);
      repeat (15) begin
         @(posedge dclk); #1;
         chk("pd_locked", locked, 0);
      end
      @(negedge dclk) pwrdwn = 1'b0;
      edges_to_lock(n);
      chk("pd_relock", n, LOCKN);

      chk("err_clear", drp_err, 0);
      @(negedge dclk);
      den = 1'b1; dwe = 1'b0; daddr = 7'h16;
      n = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge dclk); #1;
         if (i == 0) begin
            dwe = 1'b1; di = 16'h0FFF;
         end else den = 1'b0;
         if (drdy) n++;
      end
      chk("err_one_drdy", n, 1);
      chk("err_flag", drp_err, 1);
      chk("err_rd", dout, 16'h0040);
      chk("err_no_wr", divclk_div, 1);

      for (int i = 0; i < 400; i++) begin
         @(negedge dclk);
         den = ($urandom_range(0, 5) == 0);
         dwe = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 3))
            0: daddr = 7'h08;
            1: daddr = 7'h14;
            2: daddr = 7'h16;
            default: daddr = 7'($urandom_range(0, 127));
         endcase
         di = 16'($urandom);
         if ($urandom_range(0, 39) == 0) pwrdwn = ~pwrdwn;
      end
      @(negedge dclk);
      den = 1'b0; pwrdwn = 1'b0;
      chk("err_sticky", drp_err, 1);
      repeat (8) @(negedge dclk);

      den = 1'b1; dwe = 1'b1; daddr = 7'h08; di = 16'h0FFF;
      @(posedge dclk); #1;
      den = 1'b0;
      #3 rst = 1'b1;
      #1;
      chk("abort_drdy", drdy, 0);
      chk("abort_err", drp_err, 0);
      chk("abort_locked", locked, 0);
      chk("abort_dout", dout, 0);
      chk("abort_clkout0", clkout0_div, 1);
      @(negedge dclk);
      @(negedge dclk) rst = 1'b0;
      n = 0;
      repeat (10) begin
         @(posedge dclk); #1;
         if (drdy) n++;
      end
      chk("abort_no_drdy", n, 0);
      drp(1'b0, 7'h08, 16'h0000, lat, rd);
      chk("abort_reg", rd, 16'h0040);

      @(negedge dclk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
